// File: rtl/vga_console_writer.sv
// vga_console_writer
// Byte-stream front end for the 40x30 text display. Accepts bytes over a
// valid/ready handshake, tracks the cursor, interprets CR/LF/BS/FF and
// drives the video-RAM write port, clearing each row as it comes into use.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// CLEARALL   | filling every cell with FILL (after reset or FF)
// IDLE       | accepting bytes from the source
// CLRLINE    | filling the newly entered cursor row with FILL
module vga_console_writer #(
  parameter int         COLS = 40,
  parameter int         ROWS = 30,
  parameter int         AW   = 11,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] vram_waddr,
  output logic [7:0]    vram_wdata,
  output logic          vram_we,
  output logic [5:0]    cursor_col,
  output logic [4:0]    cursor_row
);

  localparam logic [1:0] S_CLEARALL = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_CLRLINE  = 2'd2;

  // The clear down-counter must hold COLS*ROWS, one bit wider than addresses.
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] CELLS     = CW'(COLS * ROWS);
  localparam logic [CW-1:0] ROW_CELLS = CW'(COLS);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [5:0]    LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);

  logic [1:0]    state;
  logic [AW-1:0] row_base;
  logic [AW-1:0] clr_ptr;
  logic [CW-1:0] clr_left;

  logic          accept;
  logic          is_ignored;
  logic [4:0]    next_row;
  logic [AW-1:0] next_base;
  logic [AW-1:0] cur_addr;

  assign in_ready   = (state == S_IDLE);
  assign accept     = in_valid && in_ready;
  // CR, LF, BS and FF are decoded before this is consulted.
  assign is_ignored = (in_data < 8'h20) || (in_data == 8'h7F);
  // Row advance wraps instead of scrolling; row_base follows without a multiply.
  assign next_row   = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
  assign next_base  = (cursor_row == LAST_ROW) ? '0 : row_base + COLS_A;
  assign cur_addr   = row_base + AW'(cursor_col);

  // Sequencer: clear engines, byte interpretation and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_CLEARALL;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= 8'h00;
      cursor_col <= 6'd0;
      cursor_row <= 5'd0;
      row_base   <= '0;
      clr_ptr    <= '0;
      clr_left   <= CELLS;
    end else begin
      vram_we <= 1'b0;
      case (state)
        S_CLEARALL, S_CLRLINE: begin
          // Ready returns one cycle after the last fill write.
          if (clr_left != '0) begin
            vram_we    <= 1'b1;
            vram_waddr <= clr_ptr;
            vram_wdata <= FILL;
            clr_ptr    <= clr_ptr + AW'(1);
            clr_left   <= clr_left - CW'(1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (accept) begin
            case (in_data)
              8'h0D: cursor_col <= 6'd0;
              8'h0A: begin
                // The first fill write goes out on the accept edge itself.
                cursor_col <= 6'd0;
                cursor_row <= next_row;
                row_base   <= next_base;
                vram_we    <= 1'b1;
                vram_waddr <= next_base;
                vram_wdata <= FILL;
                clr_ptr    <= next_base + AW'(1);
                clr_left   <= ROW_CELLS - CW'(1);
                state      <= S_CLRLINE;
              end
              8'h08: begin
                if (cursor_col != 6'd0) begin
                  cursor_col <= cursor_col - 6'd1;
                  vram_we    <= 1'b1;
                  vram_waddr <= cur_addr - AW'(1);
                  vram_wdata <= FILL;
                end
              end
              8'h0C: begin
                cursor_col <= 6'd0;
                cursor_row <= 5'd0;
                row_base   <= '0;
                vram_we    <= 1'b1;
                vram_waddr <= '0;
                vram_wdata <= FILL;
                clr_ptr    <= AW'(1);
                clr_left   <= CELLS - CW'(1);
                state      <= S_CLEARALL;
              end
              default: begin
                if (!is_ignored) begin
                  vram_we    <= 1'b1;
                  vram_waddr <= cur_addr;
                  vram_wdata <= in_data;
                  if (cursor_col == LAST_COL) begin
                    // Char write occupies this edge, so the whole row clear follows.
                    cursor_col <= 6'd0;
                    cursor_row <= next_row;
                    row_base   <= next_base;
                    clr_ptr    <= next_base;
                    clr_left   <= ROW_CELLS;
                    state      <= S_CLRLINE;
                  end else begin
                    cursor_col <= cursor_col + 6'd1;
                  end
                end
              end
            endcase
          end
        end
        default: state <= S_CLEARALL;
      endcase
    end
  end

endmodule
